uart_fifo_core: RTL and testbench

Parametrised full-duplex UART with 16x-oversampled receiver, configurable data width, optional parity, and independent TX/RX FIFOs behind valid/ready handshakes. It replaces the single-byte UART in the pipeline's MMIO path. The CPU bus adapter pushes transmit words and pops received words without polling bit timing. Transmitter and receiver are fully independent, so a transmit never blocks reception.

---
 rtl/uart_fifo_core.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with a 16x-oversampled receiver and
// independent TX/RX FIFOs behind valid/ready handshakes.
// Optional parity bit in both directions: define UART_PARITY_EN.
// Handshake rule: a word moves only on a rising edge where valid && ready;
// tx_ready is !tx_full, rx_valid is !rx_empty, rx_data is the FIFO head.
module uart_fifo_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 tx_busy,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int OS_DIV  = CLK_HZ / (BAUD * 16);
  localparam int BCW     = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int OSW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int DCW     = $clog2(DATA_BITS);
  localparam int TAW     = $clog2(TX_DEPTH);
  localparam int RAW     = $clog2(RX_DEPTH);
`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP, RX_BREAK
  } rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]         tx_wptr_q, tx_rptr_q;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                    (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rptr_q[TAW-1:0]];

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= tx_data;
  end

  // TX pointers; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e            tx_state_q;
  logic [BCW-1:0]       tx_cnt_q;
  logic [DCW-1:0]       tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_bit_end = (tx_cnt_q == BCW'(BIT_CYC - 1));
  // Pop when idle, or at the end of a stop bit so frames run back to back
  assign tx_pop  = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                 ((tx_state_q == TX_STOP) && tx_bit_end));
  assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;
  assign tx      = tx_q;

  // Transmit sequencer; the line register follows the state one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      case (tx_state_q)
        TX_START: tx_q <= 1'b0;
        TX_DATA:  tx_q <= tx_shift_q[0];
`ifdef UART_PARITY_EN
        TX_PAR:   tx_q <= tx_par_q;
`endif
        default:  tx_q <= 1'b1;
      endcase

      if ((tx_state_q == TX_IDLE) || tx_bit_end) tx_cnt_q <= '0;
      else                                       tx_cnt_q <= tx_cnt_q + 1'b1;

      if (tx_pop) begin
        tx_shift_q <= tx_head;
`ifdef UART_PARITY_EN
        tx_par_q   <= (^tx_head) ^ PAR_ODD;
`endif
        tx_state_q <= TX_START;
      end else if (tx_bit_end) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_bit_q   <= '0;
          end
          TX_DATA: begin
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_bit_q == DCW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_q <= TX_PAR;
`else
              tx_state_q <= TX_STOP;
`endif
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          TX_PAR:  tx_state_q <= TX_STOP;
`endif
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX front end ----------------
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  logic [OSW-1:0] os_cnt_q;
  logic           os_tick;

  assign os_tick = (os_cnt_q == OSW'(OS_DIV - 1));

  // Two-flop synchroniser plus previous sample for falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Free-running 16x oversample divider
  always_ff @(posedge clk) begin
    if (rst)          os_cnt_q <= '0;
    else if (os_tick) os_cnt_q <= '0;
    else              os_cnt_q <= os_cnt_q + 1'b1;
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]         rx_wptr_q, rx_rptr_q;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_stop_smp, rx_par_ok, rx_word_ok;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                    (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_valid ? rx_mem[rx_rptr_q[RAW-1:0]] : '0;
  assign rx_pop   = rx_valid && rx_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign rx_word_ok = rx_stop_smp && rx_s2_q && rx_par_ok;
  assign rx_push    = rx_word_ok && (!rx_full || rx_pop);

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= rx_shift_q;
  end

  // RX pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e      rx_state_q;
  logic [3:0]     rx_tick_q;
  logic [DCW-1:0] rx_bit_q;
  logic           rx_overrun_q, rx_frame_err_q;
`ifdef UART_PARITY_EN
  logic           rx_par_q, rx_parity_err_q;
  assign rx_par_ok     = (((^rx_shift_q) ^ PAR_ODD) == rx_par_q);
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_par_ok     = 1'b1;
  assign rx_parity_err = 1'b0;
`endif

  assign rx_stop_smp  = (rx_state_q == RX_STOP) && os_tick && (rx_tick_q == 4'd15);
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  // Receive sequencer: centre on the start bit, then sample every 16 ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q      <= RX_IDLE;
      rx_tick_q       <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_overrun_q    <= 1'b0;
      rx_frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q        <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_overrun_q   <= rx_word_ok && rx_full && !rx_pop;
      rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_q <= 1'b0;
`endif
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= '0;
          end
        end
        RX_START: begin
          if (os_tick) begin
            if (rx_tick_q == 4'd7) begin
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (os_tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == 4'd15) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == DCW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                rx_state_q <= RX_PAR;
`else
                rx_state_q <= RX_STOP;
`endif
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (os_tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == 4'd15) begin
              rx_par_q   <= rx_s2_q;
              rx_state_q <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (os_tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == 4'd15) begin
              rx_frame_err_q  <= !rx_s2_q;
`ifdef UART_PARITY_EN
              rx_parity_err_q <= !rx_par_ok;
`endif
              rx_state_q      <= rx_s2_q ? RX_IDLE : RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (rx_s2_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at BIT_CYC=16, OS_DIV=1.
module tb_uart_fifo_core;
  localparam int DB = 8;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME    = 16 * (2 + DB + PB);
  localparam int STOP_SMP = 11 + 16 * (1 + DB + PB);

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic [DB-1:0] tx_data, rx_data;
  logic          tx, rx, tx_busy, rx_overrun, rx_frame_err, rx_parity_err;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int ovr_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int rx_t0;
  logic [DB-1:0] exp_q[$];

  uart_fifo_core #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(DB),
    .TX_DEPTH(16), .RX_DEPTH(16), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx(tx), .rx(rx), .tx_busy(tx_busy),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  // clock / cycle counter / pulse counters
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rx_overrun)    ovr_cnt <= ovr_cnt + 1;
    if (rx_frame_err)  fe_cnt  <= fe_cnt + 1;
    if (rx_parity_err) pe_cnt  <= pe_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [DB-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx(input logic [DB-1:0] e);
    check("rx_valid_pop", 32'(rx_valid), 1);
    check("rx_data_pop", 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  // decode one frame whose line-low cycle starts after edge t0
  task automatic check_frame(input int t0, input logic chk_start);
    logic [DB-1:0] w;
    logic [DB-1:0] e;
    w = '0;
    if (chk_start) begin
      wait_until(t0 + 8);
      check("tx_start_bit", 32'(tx), 0);
    end
    for (int k = 0; k < DB; k++) begin
      wait_until(t0 + 24 + 16 * k);
      w[k] = tx;
    end
    e = exp_q.pop_front();
`ifdef UART_PARITY_EN
    wait_until(t0 + 16 * (1 + DB) + 8);
    check("tx_parity_bit", 32'(tx), 32'(^e));
`endif
    wait_until(t0 + 16 * (1 + DB + PB) + 8);
    check("tx_stop_bit", 32'(tx), 1);
    check("tx_word", 32'(w), 32'(e));
  endtask

  task automatic send_rx_head(input logic [DB-1:0] d, input logic par_bad);
    rx_t0 = cyc;
    rx = 1'b0;
    repeat (16) step();
    for (int k = 0; k < DB; k++) begin
      rx = d[k];
      repeat (16) step();
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ par_bad;
    repeat (16) step();
`endif
  endtask

  task automatic send_rx(input logic [DB-1:0] d, input logic stop_bit, input logic par_bad);
    send_rx_head(d, par_bad);
    rx = stop_bit;
    repeat (16) step();
  endtask

  initial begin
    int n;
    int lows;
    logic [DB-1:0] d;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx = 1'b1; rx_ready = 1'b0;
    step(); step();
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_errs", 32'({rx_overrun, rx_frame_err, rx_parity_err}), 0);
    rst = 1'b0;
    step();

    // single word: line low two edges after the handshake
    exp_q.push_back(8'hA5);
    push_tx(8'hA5);
    n = cyc;
    check("tx_busy_after_hs", 32'(tx_busy), 1);
    step();
    check("tx_high_n1", 32'(tx), 1);
    step();
    check("tx_low_n2", 32'(tx), 0);
    check_frame(n + 2, 1'b1);
    wait_until(n + FRAME);
    check("tx_busy_in_stop", 32'(tx_busy), 1);
    step();
    check("tx_busy_fall", 32'(tx_busy), 0);
    repeat (10) step();

    // FIFO fill while word 0 is on the line
    exp_q.push_back(8'h10);
    push_tx(8'h10);
    n = cyc;
    for (int i = 1; i <= 16; i++) begin
      d = DB'(8'h10 + i);
      exp_q.push_back(d);
      push_tx(d);
    end
    check("tx_ready_full", 32'(tx_ready), 0);
    push_tx(8'hEE);
    check("tx_ready_still_full", 32'(tx_ready), 0);
    for (int f = 0; f < 17; f++) check_frame(n + 2 + f * FRAME, f != 0);
    repeat (20) step();
    check("tx_idle_after_fill", 32'(tx_busy), 0);
    check("tx_ready_after_fill", 32'(tx_ready), 1);

    // RX latency, fill and overrun
    exp_q.push_back(8'h3C);
    send_rx_head(8'h3C, 1'b0);
    rx = 1'b1;
    wait_until(rx_t0 + STOP_SMP - 1);
    check("rx_valid_before_stop", 32'(rx_valid), 0);
    step();
    check("rx_valid_after_stop", 32'(rx_valid), 1);
    check("rx_data_first", 32'(rx_data), 32'h3C);
    wait_until(rx_t0 + FRAME);
    for (int i = 1; i <= 16; i++) begin
      d = DB'(i * 37);
      if (i < 16) exp_q.push_back(d);
      send_rx(d, 1'b1, 1'b0);
    end
    repeat (4) step();
    check("rx_overrun_count", 32'(ovr_cnt), 1);
    check("rx_fe_count_clean", 32'(fe_cnt), 0);
    check("rx_pe_count_clean", 32'(pe_cnt), 0);
    for (int i = 0; i < 16; i++) pop_rx(exp_q.pop_front());
    check("rx_empty_after_pops", 32'(rx_valid), 0);

    // short glitch is rejected silently
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (40) step();
    check("glitch_no_valid", 32'(rx_valid), 0);
    check("glitch_no_fe", 32'(fe_cnt), 0);

    // stop bit low: one frame error, no push, held until line returns high
    send_rx(8'h55, 1'b0, 1'b0);
    check("fe_count_one", 32'(fe_cnt), 1);
    check("fe_no_push", 32'(rx_valid), 0);
    repeat (100) step();
    check("fe_break_hold", 32'(fe_cnt), 1);
    check("fe_break_no_valid", 32'(rx_valid), 0);
    rx = 1'b1;
    repeat (20) step();
    send_rx(8'hC3, 1'b1, 1'b0);
    pop_rx(8'hC3);
    check("fe_count_final", 32'(fe_cnt), 1);

`ifdef UART_PARITY_EN
    // even parity: 0x07 carries parity 1; bad parity drops the word
    exp_q.push_back(8'h07);
    push_tx(8'h07);
    n = cyc;
    wait_until(n + 2 + 16 * (1 + DB) + 8);
    check("tx_par_07", 32'(tx), 1);
    check_frame(n + 2, 1'b1);
    repeat (20) step();
    send_rx(8'h5A, 1'b1, 1'b1);
    check("pe_count_one", 32'(pe_cnt), 1);
    check("pe_no_push", 32'(rx_valid), 0);
    send_rx(8'h07, 1'b1, 1'b0);
    pop_rx(8'h07);
    check("pe_count_final", 32'(pe_cnt), 1);
`endif

    // reset in the middle of a frame with a second word queued
    push_tx(8'hA5);
    n = cyc;
    push_tx(8'h5A);
    wait_until(n + 42);
    check("mid_tx_low", 32'(tx), 0);
    rst = 1'b1;
    step();
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_tx_ready", 32'(tx_ready), 1);
    check("rst_mid_tx_busy", 32'(tx_busy), 0);
    rst = 1'b0;
    lows = 0;
    repeat (300) begin
      step();
      if (tx == 1'b0) lows++;
    end
    check("no_resume_after_rst", 32'(lows), 0);
    check("busy_after_rst", 32'(tx_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
